// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared load/store definitions: access-size encodings, sequencer states and lane helpers.
package mem_pkg;

   typedef enum logic [2:0] {
      SZ_B  = 3'b000,
      SZ_H  = 3'b001,
      SZ_W  = 3'b010,
      SZ_BU = 3'b100,
      SZ_HU = 3'b101
   } size_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FIRST,
      ST_SECOND,
      ST_DONE
   } lsu_state_t;

   // Reserved sizeSrc codes fall back to a signed byte access.
   function automatic size_t size_norm(input logic [2:0] raw);
      case (raw)
         3'b001:  return SZ_H;
         3'b010:  return SZ_W;
         3'b100:  return SZ_BU;
         3'b101:  return SZ_HU;
         default: return SZ_B;
      endcase
   endfunction

   function automatic logic [3:0] size_mask(input size_t sz);
      case (sz)
         SZ_H, SZ_HU: return 4'b0011;
         SZ_W:        return 4'b1111;
         default:     return 4'b0001;
      endcase
   endfunction

   function automatic logic crosses(input size_t sz, input logic [1:0] off);
      case (sz)
         SZ_H, SZ_HU: return off == 2'd3;
         SZ_W:        return off != 2'd0;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// Word-wide data-memory bus with req/ack handshake and variable latency.
interface lsu_bus_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  bus_req_o;
   logic                  bus_we_o;
   logic [ADDR_WIDTH-1:0] bus_addr_o;
   logic [3:0]            bus_wstrb_o;
   logic [31:0]           bus_wdata_o;
   logic                  bus_ack_i;
   logic [31:0]           bus_rdata_i;

   modport master (
      output bus_req_o, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o,
      input  bus_ack_i, bus_rdata_i
   );

   modport slave (
      input  bus_req_o, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o,
      output bus_ack_i, bus_rdata_i
   );
endinterface

// File: rtl/lsu_bus_ctrl_load_extend.sv
// Load-data assembly: lane-align the (possibly split) read and sign/zero-extend it.
module load_extend
   import mem_pkg::*;
(
   input  logic [31:0] word0_i,
   input  logic [23:0] word1_i,
   input  logic [1:0]  off_i,
   input  size_t       size_i,
   output logic [31:0] data_o
);

   logic [31:0] raw;

   // Only the low three bytes of the second word can ever land in the result.
   always_comb begin
      case (off_i)
         2'd1:    raw = {word1_i[7:0],  word0_i[31:8]};
         2'd2:    raw = {word1_i[15:0], word0_i[31:16]};
         2'd3:    raw = {word1_i[23:0], word0_i[31:24]};
         default: raw = word0_i;
      endcase
   end

   always_comb begin
      case (size_i)
         SZ_W:    data_o = raw;
         SZ_H:    data_o = {{16{raw[15]}}, raw[15:0]};
         SZ_HU:   data_o = {16'h0000, raw[15:0]};
         SZ_BU:   data_o = {24'h000000, raw[7:0]};
         default: data_o = {{24{raw[7]}}, raw[7:0]};
      endcase
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus sequencer: lane strobes, split crossing accesses, load extension,
// pipeline stall and per-transaction timeout.
module lsu_bus_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  memRead_i,
   input  logic                  memWrite_i,
   input  logic [2:0]            sizeSrc_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           wdata_i,
   output logic                  stall_o,
   output logic                  done_o,
   output logic [31:0]           rdata_o,
   output logic                  err_o,
   lsu_bus_ctrl_if.master        bus
);

   localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_t            state_q, state_d;
   size_t                 size_q, size_d;
   logic [1:0]            off_q, off_d;
   logic                  cross_q, cross_d;
   logic                  we_q, we_d;
   logic                  req_q, req_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]            strb_q, strb_d;
   logic [3:0]            strb_hi_q, strb_hi_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           wdata_hi_q, wdata_hi_d;
   logic [31:0]           rdata0_q, rdata0_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [31:0]           rdata_q, rdata_d;

   size_t       sz_in;
   logic [7:0]  lane_in;
   logic [63:0] wsh_in;
   logic [31:0] ld_w0;
   logic [31:0] ld_data;
   logic        fin, fin_err;

   // Both halves of a split access are shifted at accept; the upper half feeds SECOND.
   assign sz_in   = size_norm(sizeSrc_i);
   assign lane_in = {4'b0000, size_mask(sz_in)} << addr_i[1:0];
   assign wsh_in  = {32'h0, wdata_i} << {addr_i[1:0], 3'b000};

   // The final word is assembled straight off the bus in its ack cycle.
   assign ld_w0 = (state_q == ST_FIRST) ? bus.bus_rdata_i : rdata0_q;

   load_extend u_load_extend (
      .word0_i (ld_w0),
      .word1_i (bus.bus_rdata_i[23:0]),
      .off_i   (off_q),
      .size_i  (size_q),
      .data_o  (ld_data)
   );

   always_comb begin
      state_d    = state_q;
      size_d     = size_q;
      off_d      = off_q;
      cross_d    = cross_q;
      we_d       = we_q;
      req_d      = req_q;
      addr_d     = addr_q;
      strb_d     = strb_q;
      strb_hi_d  = strb_hi_q;
      wdata_d    = wdata_q;
      wdata_hi_d = wdata_hi_q;
      rdata0_d   = rdata0_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      rdata_d    = '0;
      fin        = 1'b0;
      fin_err    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (memRead_i || memWrite_i) begin
               state_d    = ST_FIRST;
               size_d     = sz_in;
               off_d      = addr_i[1:0];
               cross_d    = crosses(sz_in, addr_i[1:0]);
               we_d       = memWrite_i;
               req_d      = 1'b1;
               addr_d     = {addr_i[ADDR_WIDTH-1:2], 2'b00};
               strb_d     = memWrite_i ? lane_in[3:0] : 4'b1111;
               strb_hi_d  = memWrite_i ? lane_in[7:4] : 4'b1111;
               wdata_d    = memWrite_i ? wsh_in[31:0] : '0;
               wdata_hi_d = memWrite_i ? wsh_in[63:32] : '0;
               cnt_d      = '0;
            end
         end
         ST_FIRST, ST_SECOND: begin
            if (bus.bus_ack_i) begin
               if (state_q == ST_FIRST) begin
                  rdata0_d = bus.bus_rdata_i;
               end
               if (state_q == ST_FIRST && cross_q) begin
                  state_d = ST_SECOND;
                  addr_d  = addr_q + ADDR_WIDTH'(4);
                  strb_d  = strb_hi_q;
                  wdata_d = wdata_hi_q;
                  cnt_d   = '0;
               end else begin
                  fin = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (TIMEOUT != 0 && cnt_q == TMO_LAST) begin
                  fin     = 1'b1;
                  fin_err = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (fin) begin
         state_d = ST_DONE;
         req_d   = 1'b0;
         we_d    = 1'b0;
         addr_d  = '0;
         strb_d  = '0;
         wdata_d = '0;
         done_d  = 1'b1;
         err_d   = fin_err;
         rdata_d = (!we_q && !fin_err) ? ld_data : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         size_q     <= SZ_B;
         off_q      <= '0;
         cross_q    <= 1'b0;
         we_q       <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         strb_q     <= '0;
         strb_hi_q  <= '0;
         wdata_q    <= '0;
         wdata_hi_q <= '0;
         rdata0_q   <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         size_q     <= size_d;
         off_q      <= off_d;
         cross_q    <= cross_d;
         we_q       <= we_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         strb_q     <= strb_d;
         strb_hi_q  <= strb_hi_d;
         wdata_q    <= wdata_d;
         wdata_hi_q <= wdata_hi_d;
         rdata0_q   <= rdata0_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
      end
   end

   assign stall_o = (state_q == ST_IDLE && (memRead_i || memWrite_i)) ||
                    state_q == ST_FIRST || state_q == ST_SECOND;
   assign done_o  = done_q;
   assign err_o   = err_q;
   assign rdata_o = rdata_q;

   assign bus.bus_req_o   = req_q;
   assign bus.bus_we_o    = we_q;
   assign bus.bus_addr_o  = addr_q;
   assign bus.bus_wstrb_o = strb_q;
   assign bus.bus_wdata_o = wdata_q;

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Load/store sequencer between the MEM stage and a word-wide data-memory bus with a req/ack handshake and variable latency. It takes the memory-operation controls produced by the main decoder: memWrite, resultSrc-derived load enable, and sizeSrc. It generates byte strobes and lane-shifted write data, and splits word-boundary-crossing accesses into two bus transactions. It assembles and sign/zero-extends load data, and stalls the pipeline until the access completes or times out.

Parameters:
ADDR_WIDTH, 32, byte-address width
TIMEOUT, 16, max cycles to wait for bus_ack per transaction; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
memRead_i  in  1  MEM-stage load request
memWrite_i  in  1  MEM-stage store request
sizeSrc_i  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
addr_i  in  ADDR_WIDTH  byte address (ALU result)
wdata_i  in  32  store data, right-aligned
stall_o  out  1  hold pipeline; MEM inputs stay stable while high
done_o  out  1  one-cycle completion pulse
rdata_o  out  32  extended load result, valid when done_o
err_o  out  1  timeout flag, valid with done_o
bus_req_o  out  1  bus request
bus_we_o  out  1  bus write enable
bus_addr_o  out  ADDR_WIDTH  word-aligned address, addr[1:0]=0
bus_wstrb_o  out  4  byte-lane strobes
bus_wdata_o  out  32  lane-aligned write data
bus_ack_i  in  1  transaction complete; bus_rdata_i valid same cycle
bus_rdata_i  in  32  read word

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; timeout counter 0. An in-flight transaction is abandoned, and a late bus_ack_i is ignored in IDLE.
- States are IDLE, FIRST, SECOND, DONE.
- IDLE:
  - When memRead_i|memWrite_i, go to FIRST and register the bus fields.
  - stall_o = 1 combinationally in the accept cycle.
  - If both requests are high, the write wins.
  - An undefined sizeSrc is treated as byte (000).
- Crossing rule (off = addr_i[1:0]): h crosses when off=3; w crosses when off!=0; b never crosses.
- FIRST:
  - bus_addr = {addr[hi:2],00}.
  - Write strobes are (size mask << off)[3:0], with wdata shifted left by 8*off.
  - Read strobes are 4'b1111, with bus_we=0.
  - On ack: capture rdata, then go to SECOND if crossing, else DONE.
- SECOND:
  - bus_addr = first address + 4.
  - Strobes are the residual lanes (size mask >> (4-off)).
  - wdata is the remaining high bytes in the low lanes.
  - On ack, go to DONE.
- Bus rules:
  - bus_req_o stays high continuously from entering FIRST until the final ack, including across FIRST→SECOND.
  - addr/we/strb/wdata are stable while req && !ack.
  - Ack is never sampled in IDLE or DONE.
- DONE (exactly 1 cycle):
  - done_o=1, stall_o=0, bus_req_o=0, rdata_o valid; then go to IDLE.
  - The pipeline advances at the end of this cycle.
- Load assembly: the first word is shifted right by 8*off; for crossing loads, the second word's low bytes fill the top. Then extend:
  - lb, lh: sign-extend from bit 7 / 15.
  - lbu, lhu: zero-extend.
  - lw: pass through.
  - Stores leave rdata_o = 0.
- Timeout:
  - The counter clears on every entry to FIRST and SECOND and increments each cycle of req && !ack.
  - When it reaches TIMEOUT (nonzero), go to DONE with err_o=1 and rdata_o=0. Any remaining second half is skipped.
- stall_o = (IDLE && request) || FIRST || SECOND.

Decomposition:
- Shared package mem_pkg:
  - sizeSrc encodings as an enum (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU).
  - lsu_state_t enum.
  - size-to-lane-mask function.
- Sub-module load_extend: combinational; inputs are the two read words, off, and sizeSrc; output is the 32-bit extended result.
- The FSM, strobe generation and timeout counter stay in lsu_bus_ctrl.

Test Plan:
- Aligned sw, addr 0x100, wdata 0xDEADBEEF, ack after 2 cycles → one transaction (addr 0x100, strb 1111, wdata 0xDEADBEEF); stall held 3 cycles; done pulse; err 0.
- sb, addr 0x103, wdata 0x000000AB, zero-latency ack → strb 1000, wdata 0xAB000000, addr 0x100.
- lh, addr 0x203; word @0x200 = 0x80xxxxxx, word @0x204 = 0xxxxxxxFF → two transactions (0x200 then 0x204, req continuous); rdata_o 0xFFFFFF80. Same stimulus with lhu → 0x0000FF80.
- sw, addr 0x302, wdata 0x11223344 → first transaction addr 0x300, strb 1100, wdata 0x33440000; second addr 0x304, strb 0011, wdata 0x00001122.
- lw with TIMEOUT=16 and ack never asserted → done_o with err_o=1 and rdata_o=0 after 16 wait cycles; stall drops; next request is accepted normally.
- Assert rst mid-SECOND, then pulse ack after release → all outputs 0 immediately; ack ignored; stall 0; next lb from 0x000 sign-extends correctly.
